// File: rtl/textmode_pkg.sv
// Shared definitions for the text console and the textmode display stage.
// Holds the code-point width, glyph width (also the tab stop spacing), the
// character codes the console interprets, the tram word field layout helpers
// and the console FSM state type.
package textmode_pkg;

   localparam int UCPW        = 21;
   localparam int GLYPH_WIDTH = 8;

   localparam logic [UCPW-1:0] CHR_BS    = 21'h08;
   localparam logic [UCPW-1:0] CHR_TAB   = 21'h09;
   localparam logic [UCPW-1:0] CHR_LF    = 21'h0A;
   localparam logic [UCPW-1:0] CHR_CR    = 21'h0D;
   localparam logic [UCPW-1:0] CHR_SPACE = 21'h20;

   // Tram word layout: bg in the top CIDXW bits, fg just below, ucp at the bottom.
   localparam int UCP_LSB = 0;

   function automatic int bg_lsb(input int word, input int cidxw);
      return word - cidxw;
   endfunction

   function automatic int fg_lsb(input int word, input int cidxw);
      return word - 2 * cidxw;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLR_LINE = 2'd1,
      ST_CLR_ALL  = 2'd2
   } console_state_t;

endpackage

// File: rtl/text_console_fill.sv
// tram_fill: writes one constant word per cycle to a run of tram cells.
// A start pulse loads the first address, the cell count and the word; the
// address wraps from SIZE-1 back to 0. done is high during the last write.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load a new run (ignored fields otherwise)
//   start_addr        first address of the run
//   count             number of cells to write (1..SIZE)
//   word              data written to every cell
//   we, addr, din     write port, one cell per cycle while active
//   done              high on the cycle of the final write
module tram_fill #(
   parameter int WORD  = 32,
   parameter int ADDRW = 11,
   parameter int SIZE  = 2000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ADDRW-1:0] start_addr,
   input  logic [ADDRW:0]   count,
   input  logic [WORD-1:0]  word,
   output logic             we,
   output logic [ADDRW-1:0] addr,
   output logic [WORD-1:0]  din,
   output logic             done
);

   localparam logic [ADDRW-1:0] LAST_A = ADDRW'(SIZE - 1);
   localparam logic [ADDRW:0]   ONE    = (ADDRW + 1)'(1);

   logic [ADDRW:0] remaining;

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
      end else if (start) begin
         remaining <= count;
      end else if (remaining != '0) begin
         remaining <= remaining - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         addr <= start_addr;
         din  <= word;
      end else if (remaining != '0) begin
         addr <= (addr == LAST_A) ? '0 : addr + 1'b1;
      end
   end

   assign we   = (remaining != '0);
   assign done = (remaining == ONE);

endmodule

// File: rtl/text_console.sv
// text_console: terminal-style writer feeding the textmode tram.
// Accepts Unicode code points, writes {bg, fg, ucp} words at the cursor,
// interprets LF / CR / BS (and TAB when CONSOLE_TAB_EN is defined), and
// scrolls the tram ring by advancing scroll_offs and blanking the new line.
// Optional feature macro: CONSOLE_TAB_EN (0x09 advances to the next tab stop).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   char_valid/char_ready/ucp   character input handshake
//   colr_fg, colr_bg            colours sampled at accept / clear start
//   clear                       pulse: blank whole tram and home the cursor
//   tram_we/addr/din            registered tram write port
//   scroll_offs                 tram address of the top displayed line
//   cursor_x, cursor_y          cursor column and screen-relative row
//   busy                        a line or full clear is running
module text_console
   import textmode_pkg::*;
#(
   parameter int WORD      = 32,
   parameter int ADDRW     = 11,
   parameter int CIDXW     = 4,
   parameter int TRAM_HRES = 80,
   parameter int TRAM_VRES = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             char_valid,
   output logic             char_ready,
   input  logic [UCPW-1:0]  char_ucp,
   input  logic [CIDXW-1:0] colr_fg,
   input  logic [CIDXW-1:0] colr_bg,
   input  logic             clear,
   output logic             tram_we,
   output logic [ADDRW-1:0] tram_addr,
   output logic [WORD-1:0]  tram_din,
   output logic [ADDRW-1:0] scroll_offs,
   output logic [ADDRW-1:0] cursor_x,
   output logic [ADDRW-1:0] cursor_y,
   output logic             busy
);

   localparam int               SIZE   = TRAM_HRES * TRAM_VRES;
   localparam logic [ADDRW-1:0] HRES_A = ADDRW'(TRAM_HRES);
   localparam logic [ADDRW-1:0] LAST_X = ADDRW'(TRAM_HRES - 1);
   localparam logic [ADDRW-1:0] LAST_Y = ADDRW'(TRAM_VRES - 1);
   localparam logic [ADDRW:0]   SIZE_C = (ADDRW + 1)'(SIZE);
   localparam logic [ADDRW:0]   HRES_C = (ADDRW + 1)'(TRAM_HRES);

   // Sum of two in-range addresses, reduced modulo SIZE by one subtract.
   function automatic logic [ADDRW-1:0] add_mod(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] b);
      logic [ADDRW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= SIZE_C) s = s - SIZE_C;
      return s[ADDRW-1:0];
   endfunction

   function automatic logic [WORD-1:0] make_word(input logic [CIDXW-1:0] bg,
                                                 input logic [CIDXW-1:0] fg,
                                                 input logic [UCPW-1:0]  ucp);
      logic [WORD-1:0] w;
      w = '0;
      w[bg_lsb(WORD, CIDXW) +: CIDXW] = bg;
      w[fg_lsb(WORD, CIDXW) +: CIDXW] = fg;
      w[UCP_LSB +: UCPW]              = ucp;
      return w;
   endfunction

   console_state_t   state, state_next;
   logic [ADDRW-1:0] line_addr;     // tram address of the cursor row's first cell
   logic [ADDRW-1:0] cursor_addr;
   logic             accept, printable, is_lf, is_cr, is_bs, newline_evt, scroll_evt;
   logic             fill_start, fill_we, fill_done;
   logic [ADDRW-1:0] fill_start_addr, fill_addr;
   logic [ADDRW:0]   fill_count;
   logic [WORD-1:0]  fill_din;
   logic             vld_p0;
   logic [ADDRW-1:0] addr_p0;
   logic [WORD-1:0]  din_p0;

   // A row never straddles the ring end (SIZE is a whole number of rows and
   // line_addr is row aligned), so a plain add is already in range.
   assign cursor_addr = line_addr + cursor_x;

   assign accept      = char_valid && char_ready;
   assign printable   = (char_ucp >= CHR_SPACE);
   assign is_lf       = (char_ucp == CHR_LF);
   assign is_cr       = (char_ucp == CHR_CR);
   assign is_bs       = (char_ucp == CHR_BS);
   assign newline_evt = is_lf || (printable && cursor_x == LAST_X);
   assign scroll_evt  = accept && newline_evt && (cursor_y == LAST_Y);

`ifdef CONSOLE_TAB_EN
   logic             is_tab;
   logic [ADDRW-1:0] tab_x;
   assign is_tab = (char_ucp == CHR_TAB);
   always_comb begin
      tab_x = (cursor_x | ADDRW'(GLYPH_WIDTH - 1)) + 1'b1;
      if (cursor_x >= LAST_X - ADDRW'(GLYPH_WIDTH - 1)) tab_x = LAST_X;
   end
`endif

   // Full clear starts at 0 for SIZE cells; line clear starts at the old
   // scroll_offs, which is exactly the newly exposed bottom line.
   always_comb begin
      fill_start      = 1'b0;
      fill_start_addr = scroll_offs;
      fill_count      = HRES_C;
      if (state == ST_IDLE && clear) begin
         fill_start      = 1'b1;
         fill_start_addr = '0;
         fill_count      = SIZE_C;
      end else if (scroll_evt) begin
         fill_start = 1'b1;
      end
   end

   tram_fill #(
      .WORD  (WORD),
      .ADDRW (ADDRW),
      .SIZE  (SIZE)
   ) u_fill (
      .clk        (clk),
      .rst        (rst),
      .start      (fill_start),
      .start_addr (fill_start_addr),
      .count      (fill_count),
      .word       (make_word(colr_bg, colr_fg, CHR_SPACE)),
      .we         (fill_we),
      .addr       (fill_addr),
      .din        (fill_din),
      .done       (fill_done)
   );

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (clear)           state_next = ST_CLR_ALL;
            else if (scroll_evt) state_next = ST_CLR_LINE;
         end
         ST_CLR_LINE, ST_CLR_ALL: begin
            if (fill_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      char_ready = !rst && (state == ST_IDLE) && !clear;
      busy       = (state != ST_IDLE);
   end

   // Stage p0: select the write (fill or accepted printable char)
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         addr_p0 <= '0;
         din_p0  <= '0;
      end else begin
         vld_p0 <= 1'b0;
         if (fill_we) begin
            vld_p0  <= 1'b1;
            addr_p0 <= fill_addr;
            din_p0  <= fill_din;
         end else if (accept && printable) begin
            vld_p0  <= 1'b1;
            addr_p0 <= cursor_addr;
            din_p0  <= make_word(colr_bg, colr_fg, char_ucp);
         end
      end
   end

   // Stage p1: registered tram port
   always_ff @(posedge clk) begin
      if (rst) begin
         tram_we   <= 1'b0;
         tram_addr <= '0;
         tram_din  <= '0;
      end else begin
         tram_we   <= vld_p0;
         tram_addr <= addr_p0;
         tram_din  <= din_p0;
      end
   end

   // Cursor and scroll tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         cursor_x    <= '0;
         cursor_y    <= '0;
         line_addr   <= '0;
         scroll_offs <= '0;
      end else if (state == ST_CLR_ALL && fill_done) begin
         cursor_x    <= '0;
         cursor_y    <= '0;
         line_addr   <= '0;
         scroll_offs <= '0;
      end else if (accept) begin
         if (newline_evt) begin
            cursor_x  <= '0;
            line_addr <= add_mod(line_addr, HRES_A);
            if (cursor_y == LAST_Y) scroll_offs <= add_mod(scroll_offs, HRES_A);
            else                    cursor_y    <= cursor_y + 1'b1;
         end else if (is_cr) begin
            cursor_x <= '0;
         end else if (is_bs) begin
            if (cursor_x != '0) cursor_x <= cursor_x - 1'b1;
`ifdef CONSOLE_TAB_EN
         end else if (is_tab) begin
            cursor_x <= tab_x;
`endif
         end else if (printable) begin
            cursor_x <= cursor_x + 1'b1;
         end
      end
   end

endmodule
